// File: rtl/sar_avg_decim_if.sv
// ---------------------------------------------------------------------------
// sar_avg_decim_if
// Bundles the conversion input, the averaged-result handshake and the
// overrun status of sar_avg_decim.
//   SAR_ADC_decision [N]       completed conversion code from the SAR FSM
//   conv_done                  one-cycle strobe, code valid in same cycle
//   avg_out          [N]       averaged code
//   avg_valid                  avg_out holds an unconsumed result
//   avg_ready                  downstream accepts avg_out
//   overrun                    sticky: a completed average was dropped
//   ovr_clr                    one-cycle clear of overrun
//   acc_cnt          [LOG2_AVG] conversions accumulated in current block
// Modports: slave = the averager, master = the environment driving it.
// ---------------------------------------------------------------------------
interface sar_avg_decim_if #(
    parameter int N        = 4,
    parameter int LOG2_AVG = 2
);
    logic [N-1:0]        SAR_ADC_decision;
    logic                conv_done;
    logic [N-1:0]        avg_out;
    logic                avg_valid;
    logic                avg_ready;
    logic                overrun;
    logic                ovr_clr;
    logic [LOG2_AVG-1:0] acc_cnt;

    modport slave (
        input  SAR_ADC_decision, conv_done, avg_ready, ovr_clr,
        output avg_out, avg_valid, overrun, acc_cnt
    );

    modport master (
        output SAR_ADC_decision, conv_done, avg_ready, ovr_clr,
        input  avg_out, avg_valid, overrun, acc_cnt
    );
endinterface

// File: rtl/sar_avg_decim.sv
// ---------------------------------------------------------------------------
// sar_avg_decim
// Averages 2^LOG2_AVG consecutive SAR conversion codes and presents each
// average on a valid/ready output held in a one-entry buffer. A block that
// completes while the buffer is still full is dropped and flagged through
// the sticky overrun bit.
//
// Ports:
//   clk_1Mhz  single system clock, rising edge
//   reset     synchronous, active-high
//   bus       sar_avg_decim_if.slave (see interface for signal list)
//
// Parameters:
//   N         conversion code width
//   LOG2_AVG  log2 of conversions per average (1..6)
//
// Build option:
//   SAR_AVG_ROUND_EN  defined  -> round-half-up of the block average
//                     undefined -> truncation (default)
// ---------------------------------------------------------------------------
module sar_avg_decim #(
    parameter int N        = 4,
    parameter int LOG2_AVG = 2
) (
    input  logic            clk_1Mhz,
    input  logic            reset,
    sar_avg_decim_if.slave  bus
);

    // Holds the sum of 2^LOG2_AVG codes of N bits with no overflow.
    localparam int ACC_W = N + LOG2_AVG;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_AVG-1:0] acc_cnt_q, acc_cnt_d;
    logic [N-1:0]        avg_out_q, avg_out_d;
    logic                overrun_q, overrun_d;

    logic [ACC_W-1:0]    sum;
    logic [N-1:0]        result;
    logic                last_conv;
    logic                complete;
    logic                transfer;
    logic                drop;

    // Divide the block sum by 2^LOG2_AVG. With rounding, the added half-LSB
    // cannot carry past ACC_W bits and the largest sum still maps to 2^N-1.
    function automatic logic [N-1:0] scale_sum(input logic [ACC_W-1:0] s);
`ifdef SAR_AVG_ROUND_EN
        return N'((s + ACC_W'(1 << (LOG2_AVG - 1))) >> LOG2_AVG);
`else
        return N'(s >> LOG2_AVG);
`endif
    endfunction

    assign sum       = acc_q + ACC_W'(bus.SAR_ADC_decision);
    assign result    = scale_sum(sum);
    assign last_conv = (acc_cnt_q == '1);
    assign complete  = bus.conv_done && last_conv;
    assign transfer  = (state_q == FULL) && bus.avg_ready;

    // Accumulator: the final strobe of a block clears it for the next one.
    always_comb begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        if (bus.conv_done) begin
            if (last_conv) begin
                acc_d     = '0;
                acc_cnt_d = '0;
            end else begin
                acc_d     = sum;
                acc_cnt_d = acc_cnt_q + LOG2_AVG'(1);
            end
        end
    end

    // Output buffer FSM. A completion coinciding with a transfer reloads the
    // buffer directly so the consumer sees no idle cycle.
    always_comb begin
        state_d   = state_q;
        avg_out_d = avg_out_q;
        drop      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d   = FULL;
                    avg_out_d = result;
                end
            end
            FULL: begin
                if (complete && transfer) begin
                    avg_out_d = result;
                end else if (complete) begin
                    drop = 1'b1;
                end else if (transfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // A new drop wins over a simultaneous clear.
    assign overrun_d = drop | (overrun_q & ~bus.ovr_clr);

    always_ff @(posedge clk_1Mhz) begin
        if (reset) begin
            state_q   <= EMPTY;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            avg_out_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            avg_out_q <= avg_out_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.avg_out   = avg_out_q;
    assign bus.avg_valid = (state_q == FULL);
    assign bus.overrun   = overrun_q;
    assign bus.acc_cnt   = acc_cnt_q;

endmodule

// File: doc/sar_avg_decim.md
SAR_AVG_DECIM -- requirements
Module: sar_avg_decim

Interface
REQ-001 Parameter N, default 4: SAR conversion code width in bits.
REQ-002 Parameter LOG2_AVG, default 2: log2 of conversions averaged per output; legal range 1..6.
REQ-003 clk_1Mhz  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SAR_ADC_decision  input  N  completed conversion code from the SAR FSM.
REQ-006 conv_done  input  1  one-cycle strobe; SAR_ADC_decision is valid in the same cycle.
REQ-007 avg_out  output  N  averaged code.
REQ-008 avg_valid  output  1  avg_out holds an unconsumed result.
REQ-009 avg_ready  input  1  downstream accepts avg_out.
REQ-010 overrun  output  1  sticky: a completed average was dropped.
REQ-011 ovr_clr  input  1  one-cycle clear of overrun.
REQ-012 acc_cnt  output  LOG2_AVG  conversions accumulated in the current block.

Function
REQ-013 The accumulator SHALL be N+LOG2_AVG bits wide and never overflow.
REQ-014 On conv_done with acc_cnt < 2^LOG2_AVG-1: acc += SAR_ADC_decision and acc_cnt += 1.
REQ-015 On conv_done with acc_cnt = 2^LOG2_AVG-1, the block completes.
  - result = (acc + SAR_ADC_decision) >> LOG2_AVG.
  - acc and acc_cnt clear to 0 in the same edge.
REQ-016 The output FSM SHALL have two states:
  - EMPTY: avg_valid=0.
  - FULL: avg_valid=1.
REQ-017 EMPTY -> FULL on a block completion; avg_out loads the result; avg_valid rises one cycle after the final conv_done.
REQ-018 A transfer SHALL occur when avg_valid and avg_ready are both 1 at a rising edge.
  - FULL -> EMPTY on a transfer with no simultaneous completion.
REQ-019 A transfer and a completion in the same cycle SHALL stay in FULL and load the new result (no bubble).
REQ-020 A completion in FULL without a transfer SHALL:
  - drop the new result;
  - keep avg_out unchanged;
  - set overrun to 1 the next cycle.
REQ-021 avg_out SHALL be stable while avg_valid=1 and not transferred.
REQ-022 overrun SHALL stay 1 until ovr_clr or reset.
  - A set and an ovr_clr in the same cycle leave overrun at 1.
REQ-023 conv_done=0 SHALL leave acc and acc_cnt unchanged.
REQ-024 SAR_ADC_decision SHALL be ignored when conv_done=0.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL clear:
  - acc=0, acc_cnt=0, avg_out=0, avg_valid=0 (EMPTY), overrun=0.
REQ-026 Reset SHALL take priority over conv_done, avg_ready and ovr_clr in the same cycle.
  - A partially accumulated block is discarded.
  - The first full block after reset starts from acc_cnt=0.

Configuration
REQ-027 Macro SAR_AVG_ROUND_EN SHALL control rounding of the result.
  - Defined: result = (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG, round-half-up; the maximum sum still yields 2^N-1, so no saturation logic.
  - Undefined: result = sum >> LOG2_AVG, truncation.
  - All other behaviour is identical.

Verification
REQ-028 Averaging, N=4, LOG2_AVG=2:
  - Codes 3,5,7,9 on four conv_done strobes, avg_ready=1 -> avg_out=6.
  - avg_valid high exactly one cycle, starting the cycle after the 4th strobe.
REQ-029 Rounding:
  - Codes 1,2,2,2 -> avg_out=2 with SAR_AVG_ROUND_EN, 1 without.
  - Codes 15,15,15,15 -> 15 in both builds.
REQ-030 Backpressure:
  - avg_ready=0 for two blocks (3,5,7,9 then 15,15,15,15) -> avg_out stays 6, overrun=1.
  - Then avg_ready=1 -> one transfer of 6, then avg_valid=0.
REQ-031 Same-cycle transfer and completion: avg_valid=1 with avg_ready=1 on the cycle of the final strobe of the next block -> avg_valid stays 1, avg_out updates to the new value, overrun=0.
REQ-032 Reset mid-block:
  - Two strobes (15,15), then reset=1 for one cycle -> acc_cnt=0.
  - Then codes 1,1,1,1 -> avg_out=1.
REQ-033 ovr_clr:
  - Pulse ovr_clr after an overrun -> overrun=0 next cycle.
  - ovr_clr coincident with a new drop -> overrun remains 1.
